alu_operand_stage: RTL and testbench
====================================

ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 Parameter WIDTH, default 32: datapath width of operands and register data.
REQ-002 Parameter IMM_W, default 16: immediate width; SHALL satisfy IMM_W <= WIDTH.
REQ-003 Parameter SHAMT_W, default 5: shift-amount width.
REQ-004 Parameter REG_AW, default 5: register-number width.
REQ-005 Parameter CNT_W, default 16: stall-counter width.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 in_valid  in  1  upstream operand bundle valid.
REQ-009 in_ready  out  1  stage can accept a bundle this cycle.
REQ-010 srcA_sel  in  3  A select: 0 reg_out1; 1 shamt zero-extended; 2 pc; 3-7 zero.
REQ-011 srcB_sel  in  3  B select: 0 reg_out2; 1 sign-extended imm; 2 zero-extended imm; 3 imm placed in the top IMM_W bits with low bits zero; 4 constant 4; 5-7 zero.
REQ-012 rs, rt  in  REG_AW each  source register numbers for reg_out1 and reg_out2.
REQ-013 reg_out1, reg_out2, pc  in  WIDTH each  register-file outputs and instruction address.
REQ-014 imm  in  IMM_W; shamt  in  SHAMT_W.
REQ-015 fwd_ex_we, fwd_wb_we  in  1 each  younger (EX/MEM) and older (MEM/WB) write enables.
REQ-016 fwd_ex_addr, fwd_wb_addr  in  REG_AW each; fwd_ex_data, fwd_wb_data  in  WIDTH each.
REQ-017 flush  in  1  synchronous discard of the held bundle.
REQ-018 A, B  out  WIDTH each  registered operands.
REQ-019 out_valid  in/out: out_valid out 1, out_ready in 1  downstream handshake.
REQ-020 stall_cnt  out  CNT_W  saturating count of back-pressure cycles.

Function
REQ-021 Register-operand resolution: if fwd_ex_we, fwd_ex_addr != 0 and fwd_ex_addr == rs, value = fwd_ex_data; else if the same holds for the WB port, value = fwd_wb_data; else value = reg_out1. The same rules with rt select the resolved reg_out2.
REQ-022 Register number 0 SHALL never be forwarded; EX port SHALL win when both ports match.
REQ-023 Forwarding applies only when the select chooses a register source; immediate, shamt, pc and constant sources are unaffected.
REQ-024 in_ready = !out_valid || out_ready (combinational; no dependence on in_valid).
REQ-025 Capture: when in_valid && in_ready && !flush, A and B load the resolved, selected operands and out_valid becomes 1 on the next edge; latency is exactly one cycle.
REQ-026 When out_valid && out_ready and no capture, out_valid clears; A and B hold their values.
REQ-027 When out_valid && !out_ready, A, B and out_valid SHALL hold unchanged regardless of inputs.
REQ-028 Simultaneous drain and capture (out_valid, out_ready, in_valid) SHALL replace the bundle with no bubble; out_valid stays 1.
REQ-029 flush SHALL clear out_valid on the next edge and block any capture in that cycle; A and B hold.
REQ-030 stall_cnt increments by 1 on each edge where out_valid && !out_ready, saturating at all-ones; it is not cleared by flush.
REQ-031 Sign-extension replicates imm[IMM_W-1]; zero-extension and shamt extension fill with 0; when IMM_W == WIDTH select 3 equals imm.

Reset
REQ-032 While rst is high: A = 0, B = 0, out_valid = 0, stall_cnt = 0, effective immediately without a clock edge.
REQ-033 Reset asserted mid-transfer SHALL discard the held bundle; first capture is possible on the first rising edge after rst falls.

Verification
REQ-034 Select sweep, no forwarding: imm=16'h8001, shamt=5'd7, reg_out1=32'h11, pc=32'h400 -> B: sel1 32'hFFFF8001, sel2 32'h00008001, sel3 32'h80010000, sel4 32'h4; A: sel1 32'h7, sel2 32'h400, sel5 32'h0, one cycle after capture.
REQ-035 Forwarding priority: rs=3, fwd_ex (we=1, addr=3, data=32'hAA), fwd_wb (we=1, addr=3, data=32'hBB) -> A=32'hAA; EX we=0 -> A=32'hBB; rs=0 with both matching addr 0 -> A=reg_out1.
REQ-036 Back-pressure: capture bundle X, hold out_ready=0 for 5 cycles while inputs change -> A/B stay X, in_ready=0, stall_cnt=5; then out_ready=1 with in_valid=1 -> new bundle next edge, out_valid stays 1.
REQ-037 Flush: out_valid=1, assert flush with in_valid=1, out_ready=0 -> out_valid=0 next edge, A/B unchanged, stall_cnt unchanged by flush.
REQ-038 Async reset: assert rst between edges while out_valid=1 -> A=0, B=0, out_valid=0, stall_cnt=0 before next edge.
REQ-039 Saturation with CNT_W=4: 20 stalled cycles -> stall_cnt=4'hF.

Source files
------------

// File: rtl/alu_operand_stage.sv
// Operand stage: forwards EX/WB results onto register sources, selects A/B,
// and holds them in a single valid/ready output register with a stall counter.
module alu_fwd_resolve #(
    parameter int WIDTH  = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] addr,
    input  logic [WIDTH-1:0]  reg_val,
    input  logic              ex_we,
    input  logic [REG_AW-1:0] ex_addr,
    input  logic [WIDTH-1:0]  ex_data,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [WIDTH-1:0]  wb_data,
    output logic [WIDTH-1:0]  val
);
    logic ex_hit, wb_hit;

    // r0 is hard-wired zero, so a write to it must never be forwarded
    assign ex_hit = ex_we && (ex_addr != '0) && (ex_addr == addr);
    assign wb_hit = wb_we && (wb_addr != '0) && (wb_addr == addr);
    assign val    = ex_hit ? ex_data : (wb_hit ? wb_data : reg_val);
endmodule

module alu_operand_stage #(
    parameter int WIDTH   = 32,
    parameter int IMM_W   = 16,
    parameter int SHAMT_W = 5,
    parameter int REG_AW  = 5,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         srcA_sel,
    input  logic [2:0]         srcB_sel,
    input  logic [REG_AW-1:0]  rs,
    input  logic [REG_AW-1:0]  rt,
    input  logic [WIDTH-1:0]   reg_out1,
    input  logic [WIDTH-1:0]   reg_out2,
    input  logic [WIDTH-1:0]   pc,
    input  logic [IMM_W-1:0]   imm,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               fwd_ex_we,
    input  logic               fwd_wb_we,
    input  logic [REG_AW-1:0]  fwd_ex_addr,
    input  logic [REG_AW-1:0]  fwd_wb_addr,
    input  logic [WIDTH-1:0]   fwd_ex_data,
    input  logic [WIDTH-1:0]   fwd_wb_data,
    input  logic               flush,
    output logic [WIDTH-1:0]   A,
    output logic [WIDTH-1:0]   B,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CNT_W-1:0]   stall_cnt
);
    localparam int NUM_SRC = 2;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } opnd_t;

    logic [NUM_SRC-1:0][REG_AW-1:0] src_addr;
    logic [NUM_SRC-1:0][WIDTH-1:0]  src_reg;
    logic [NUM_SRC-1:0][WIDTH-1:0]  src_res;
    opnd_t                          nxt;
    logic                           capture;

    assign src_addr = {rt, rs};
    assign src_reg  = {reg_out2, reg_out1};

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_fwd
        alu_fwd_resolve #(.WIDTH(WIDTH), .REG_AW(REG_AW)) u_fwd (
            .addr    (src_addr[g]),
            .reg_val (src_reg[g]),
            .ex_we   (fwd_ex_we),
            .ex_addr (fwd_ex_addr),
            .ex_data (fwd_ex_data),
            .wb_we   (fwd_wb_we),
            .wb_addr (fwd_wb_addr),
            .wb_data (fwd_wb_data),
            .val     (src_res[g])
        );
    end

    always_comb begin
        nxt = '0;
        case (srcA_sel)
            3'd0:    nxt.a = src_res[0];
            3'd1:    nxt.a = WIDTH'(shamt);
            3'd2:    nxt.a = pc;
            default: nxt.a = '0;
        endcase
        // casts/shift keep these legal when IMM_W == WIDTH
        case (srcB_sel)
            3'd0:    nxt.b = src_res[1];
            3'd1:    nxt.b = WIDTH'($signed(imm));
            3'd2:    nxt.b = WIDTH'(imm);
            3'd3:    nxt.b = WIDTH'(imm) << (WIDTH - IMM_W);
            3'd4:    nxt.b = WIDTH'(4);
            default: nxt.b = '0;
        endcase
    end

    assign in_ready = !out_valid || out_ready;
    assign capture  = in_valid && in_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            A         <= '0;
            B         <= '0;
            out_valid <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (capture) begin
                A <= nxt.a;
                B <= nxt.b;
            end
            if (flush)
                out_valid <= 1'b0;
            else if (capture)
                out_valid <= 1'b1;
            else if (out_ready)
                out_valid <= 1'b0;
            if (out_valid && !out_ready && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench: select/forwarding table plus handshake, flush, reset and
// counter-saturation sequences.
module tb_alu_operand_stage;
    logic        clk = 0, rst = 1;
    logic        in_valid = 0, out_ready = 1, flush = 0;
    logic [2:0]  srcA_sel = 0, srcB_sel = 0;
    logic [4:0]  rs = 0, rt = 0, fwd_ex_addr = 0, fwd_wb_addr = 0;
    logic [31:0] reg_out1 = 0, reg_out2 = 0, pc = 0, fwd_ex_data = 0, fwd_wb_data = 0;
    logic [15:0] imm = 0;
    logic [4:0]  shamt = 0;
    logic        fwd_ex_we = 0, fwd_wb_we = 0;
    logic [31:0] A, B, A2, B2;
    logic        in_ready, out_valid, in_ready2, out_valid2;
    logic [15:0] stall_cnt;
    logic [3:0]  stall_cnt2;
    int          total = 0, passed = 0;

    always #5 clk = ~clk;

    alu_operand_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .srcA_sel(srcA_sel), .srcB_sel(srcB_sel), .rs(rs), .rt(rt),
        .reg_out1(reg_out1), .reg_out2(reg_out2), .pc(pc), .imm(imm), .shamt(shamt),
        .fwd_ex_we(fwd_ex_we), .fwd_wb_we(fwd_wb_we), .fwd_ex_addr(fwd_ex_addr),
        .fwd_wb_addr(fwd_wb_addr), .fwd_ex_data(fwd_ex_data), .fwd_wb_data(fwd_wb_data),
        .flush(flush), .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
        .stall_cnt(stall_cnt)
    );

    alu_operand_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .srcA_sel(srcA_sel), .srcB_sel(srcB_sel), .rs(rs), .rt(rt),
        .reg_out1(reg_out1), .reg_out2(reg_out2), .pc(pc), .imm(imm), .shamt(shamt),
        .fwd_ex_we(fwd_ex_we), .fwd_wb_we(fwd_wb_we), .fwd_ex_addr(fwd_ex_addr),
        .fwd_wb_addr(fwd_wb_addr), .fwd_ex_data(fwd_ex_data), .fwd_wb_data(fwd_wb_data),
        .flush(flush), .A(A2), .B(B2), .out_valid(out_valid2), .out_ready(out_ready),
        .stall_cnt(stall_cnt2)
    );

    typedef struct {
        logic [2:0]  asel, bsel;
        logic [4:0]  rs, rt;
        logic        ex_we;
        logic [4:0]  ex_addr;
        logic [31:0] ex_data;
        logic        wb_we;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic [31:0] exp_a, exp_b;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bundle(input logic [2:0] as, input logic [2:0] bs,
                              input logic [31:0] r1, input logic [31:0] r2);
        srcA_sel = as; srcB_sel = bs; reg_out1 = r1; reg_out2 = r2;
        rs = 5'd1; rt = 5'd2; fwd_ex_we = 0; fwd_wb_we = 0;
    endtask

    initial begin
        vecs[0] = '{0, 1, 1, 2, 0, 0, 0,     0, 0, 0,     32'h11,  32'hFFFF8001};
        vecs[1] = '{1, 2, 1, 2, 0, 0, 0,     0, 0, 0,     32'h7,   32'h00008001};
        vecs[2] = '{2, 3, 1, 2, 0, 0, 0,     0, 0, 0,     32'h400, 32'h80010000};
        vecs[3] = '{5, 4, 1, 2, 0, 0, 0,     0, 0, 0,     32'h0,   32'h4};
        vecs[4] = '{0, 0, 3, 4, 1, 3, 'hAA,  1, 3, 'hBB,  32'hAA,  32'h22};
        vecs[5] = '{0, 0, 3, 4, 0, 3, 'hAA,  1, 3, 'hBB,  32'hBB,  32'h22};
        vecs[6] = '{0, 0, 0, 4, 1, 0, 'hAA,  1, 0, 'hBB,  32'h11,  32'h22};
        vecs[7] = '{0, 0, 3, 4, 1, 3, 'hAA,  1, 4, 'hCC,  32'hAA,  32'hCC};
        vecs[8] = '{1, 1, 3, 4, 1, 3, 'hAA,  1, 4, 'hCC,  32'h7,   32'hFFFF8001};
        vecs[9] = '{7, 7, 1, 2, 0, 0, 0,     0, 0, 0,     32'h0,   32'h0};

        imm = 16'h8001; shamt = 5'd7; pc = 32'h400;
        #12;
        check("rst_A", A, 0);
        check("rst_B", B, 0);
        check("rst_valid", {31'b0, out_valid}, 0);
        check("rst_stall", {16'b0, stall_cnt}, 0);
        check("rst_in_ready", {31'b0, in_ready}, 1);
        @(negedge clk); rst = 0;

        // select / forwarding table
        reg_out1 = 32'h11; reg_out2 = 32'h22;
        for (int i = 0; i < 10; i++) begin
            srcA_sel = vecs[i].asel; srcB_sel = vecs[i].bsel;
            rs = vecs[i].rs; rt = vecs[i].rt;
            fwd_ex_we = vecs[i].ex_we; fwd_ex_addr = vecs[i].ex_addr; fwd_ex_data = vecs[i].ex_data;
            fwd_wb_we = vecs[i].wb_we; fwd_wb_addr = vecs[i].wb_addr; fwd_wb_data = vecs[i].wb_data;
            in_valid = 1; out_ready = 1;
            step();
            check($sformatf("vec%0d_A", i), A, vecs[i].exp_a);
            check($sformatf("vec%0d_B", i), B, vecs[i].exp_b);
            check($sformatf("vec%0d_valid", i), {31'b0, out_valid}, 1);
        end
        in_valid = 0;
        step();
        check("drain_valid", {31'b0, out_valid}, 0);
        check("drain_hold_A", A, 0);
        check("stall_zero", {16'b0, stall_cnt}, 0);

        // back-pressure
        set_bundle(0, 0, 32'h1234, 32'h5678);
        in_valid = 1; out_ready = 1;
        step();
        out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            reg_out1 = 32'hDEAD0000 + i; reg_out2 = 32'hBEEF0000 + i; srcA_sel = 3'(i);
            step();
        end
        check("bp_A", A, 32'h1234);
        check("bp_B", B, 32'h5678);
        check("bp_valid", {31'b0, out_valid}, 1);
        check("bp_in_ready", {31'b0, in_ready}, 0);
        check("bp_stall", {16'b0, stall_cnt}, 5);
        set_bundle(0, 4, 32'h9999, 32'h0);
        out_ready = 1;
        #1;
        check("bp_in_ready_rel", {31'b0, in_ready}, 1);
        step();
        check("bp_new_A", A, 32'h9999);
        check("bp_new_B", B, 32'h4);
        check("bp_no_bubble", {31'b0, out_valid}, 1);
        check("bp_stall_kept", {16'b0, stall_cnt}, 5);

        // flush while stalled
        out_ready = 0; flush = 1;
        set_bundle(2, 1, 32'h7777, 32'h8888);
        step();
        flush = 0; in_valid = 0;
        check("fl_valid", {31'b0, out_valid}, 0);
        check("fl_A", A, 32'h9999);
        check("fl_B", B, 32'h4);
        check("fl_stall", {16'b0, stall_cnt}, 6);

        // async reset mid-cycle
        out_ready = 1; in_valid = 1;
        set_bundle(0, 0, 32'hCAFE, 32'hF00D);
        step();
        check("ar_pre_valid", {31'b0, out_valid}, 1);
        in_valid = 0;
        #2 rst = 1;
        #1;
        check("ar_A", A, 0);
        check("ar_B", B, 0);
        check("ar_valid", {31'b0, out_valid}, 0);
        check("ar_stall", {16'b0, stall_cnt}, 0);
        @(negedge clk); rst = 0;
        in_valid = 1;
        step();
        check("ar_first_cap", A, 32'hCAFE);

        // saturation on the 4-bit counter instance
        out_ready = 0; in_valid = 0;
        for (int i = 0; i < 20; i++) step();
        check("sat_cnt4", {28'b0, stall_cnt2}, 32'hF);
        check("sat_cnt16", {16'b0, stall_cnt}, 20);
        check("sat_hold_A", A2, 32'hCAFE);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: sim time exceeded, expected completion");
        $fatal(1);
    end
endmodule
